// File: rtl/mips_ctrl_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the CPU run controller:
//   - run_mode_e : encoding of the 2-bit run-mode input (RUN/DIV/STEP/HALT)
//   - CNT_W      : width of the issued-tick counter
//   - STR_W      : width of the reset stretch counter
//   - sat_inc8() : saturating 8-bit increment used by the stretch counter
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } run_mode_e;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned STR_W = 8;

    // Increment cur by one, but never beyond lim.
    function automatic logic [STR_W-1:0] sat_inc8(input logic [STR_W-1:0] cur,
                                                  input logic [STR_W-1:0] lim);
        logic [STR_W-1:0] res;
        if (cur < lim) begin
            res = cur + 8'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage : mips_ctrl_pkg

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises a raw active-low push button, filters bounce with a stability
// counter and emits a one-cycle strobe on every debounced press (1->0).
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset
//   key_i   in  1  raw key level, asynchronous to clk_i, active-low
//   pulse_o out 1  registered one-cycle strobe per debounced press
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned DEB_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic pulse_o
);

    // DEB_CYC >= 2, so CW >= 1 and DEB_CYC-1 always fits in CW bits.
    localparam int unsigned     CW   = $clog2(DEB_CYC);
    localparam logic [CW-1:0]   LAST = CW'(DEB_CYC - 1);

    logic [1:0]    sync_q;
    logic          sample_s;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Two-stage synchroniser; idles at 1 (key released).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign sample_s = sync_q[1];

    // Stability filter: the level only follows the sample after DEB_CYC
    // consecutive samples that disagree with the current level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sample_s != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sample_s;
                cnt_d   = '0;
                pulse_d = ~sample_s;   // press only; release gives no strobe
            end else begin
                cnt_d   = cnt_q + CW'(1'b1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounced level, stability counter and press strobe registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : key_debounce

// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for a small CPU: generates a stretched core reset, a tick
// (RUN every cycle, DIV once per div_val+1 cycles, STEP per debounced key
// press, HALT never), per-channel registered clock enables and a tick counter.
// Ports:
//   CLOCK_50   in  1      sole clock, rising edge
//   RST_N      in  1      asynchronous active-low reset
//   mode       in  2      run mode (see mips_ctrl_pkg::run_mode_e)
//   div_val    in  DIV_W  DIV ratio, one tick per div_val+1 cycles
//   ch_en      in  N_CH   per-channel enable mask
//   step_key   in  1      raw active-low push button
//   clr_cnt    in  1      synchronous clear of cycle_cnt (wins over a tick)
//   core_rst   out 1      active-high reset to the CPU core
//   ce         out N_CH   registered clock enables (tick & ch_en, latency 1)
//   cycle_cnt  out 32     number of ticks issued, wraps
//   step_pulse out 1      one-cycle strobe per debounced press
// -----------------------------------------------------------------------------
module cpu_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned STRETCH = 8,
    parameter int unsigned DEB_CYC = 1000
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             step_key,
    input  logic             clr_cnt,
    output logic             core_rst,
    output logic [N_CH-1:0]  ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             step_pulse
);

    localparam logic [STR_W-1:0] STRETCH_LIM = STR_W'(STRETCH);

    // ---------------------------------------------------------------- reset
    logic [1:0]       rst_sync_q;     // 1 = reset still asserted
    logic             rst_int_n_s;
    logic [STR_W-1:0] stretch_q, stretch_d;
    logic             core_rst_q, core_rst_d;

    // Reset synchroniser: asserts asynchronously, releases after two edges.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    // Everything downstream is reset by the synchronised reset, so assertion
    // stays immediate while release is aligned to CLOCK_50.
    assign rst_int_n_s = ~rst_sync_q[1];

    // Core reset stays high until the stretch counter reaches STRETCH; the
    // decision uses the next counter value so core_rst itself is registered.
    always_comb begin
        stretch_d  = sat_inc8(stretch_q, STRETCH_LIM);
        core_rst_d = (stretch_d < STRETCH_LIM);
    end

    // Stretch counter and registered core reset.
    always_ff @(posedge CLOCK_50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            stretch_q  <= '0;
            core_rst_q <= 1'b1;
        end else begin
            stretch_q  <= stretch_d;
            core_rst_q <= core_rst_d;
        end
    end

    // ------------------------------------------------------------ step key
    logic step_pulse_s;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key_debounce (
        .clk_i   (CLOCK_50),
        .rst_ni  (rst_int_n_s),
        .key_i   (step_key),
        .pulse_o (step_pulse_s)
    );

    // ------------------------------------------------------------ tick gen
    run_mode_e        mode_s;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic             cfg_chg_s;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_raw_s;
    logic             tick_s;

    assign mode_s    = run_mode_e'(mode);
    // Any change of mode or ratio restarts the divider from zero.
    assign cfg_chg_s = (mode != mode_q) || (div_val != div_q);

    // Mode-dependent tick and divider next state.
    always_comb begin
        tick_raw_s = 1'b0;
        div_cnt_d  = '0;
        case (mode_s)
            MODE_RUN: begin
                tick_raw_s = 1'b1;
            end
            MODE_DIV: begin
                if (cfg_chg_s) begin
                    // Change cycle only clears the counter, so the first tick
                    // lands div_val+1 cycles later.
                    tick_raw_s = 1'b0;
                    div_cnt_d  = '0;
                end else if (div_cnt_q == div_val) begin
                    tick_raw_s = 1'b1;
                    div_cnt_d  = '0;
                end else begin
                    tick_raw_s = 1'b0;
                    div_cnt_d  = div_cnt_q + DIV_W'(1'b1);
                end
            end
            MODE_STEP: begin
                tick_raw_s = step_pulse_s;
            end
            MODE_HALT: begin
                tick_raw_s = 1'b0;
            end
            default: begin
                tick_raw_s = 1'b0;
            end
        endcase
    end

    // No ticks at all while the core is held in reset.
    assign tick_s = tick_raw_s & ~core_rst_q;

    // Configuration history and divider counter.
    always_ff @(posedge CLOCK_50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            mode_q    <= MODE_RUN;
            div_q     <= '0;
            div_cnt_q <= '0;
        end else begin
            mode_q    <= mode;
            div_q     <= div_val;
            div_cnt_q <= core_rst_q ? '0 : div_cnt_d;
        end
    end

    // ------------------------------------------------------ outputs / count
    logic [N_CH-1:0]  ce_q, ce_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Enable mask and tick counter next state; clear beats a same-cycle tick.
    always_comb begin
        ce_d = {N_CH{tick_s}} & ch_en;
        if (clr_cnt) begin
            cnt_d = 32'h0000_0000;
        end else begin
            cnt_d = cnt_q + {31'b0, tick_s};
        end
    end

    // Clock-enable and counter registers.
    always_ff @(posedge CLOCK_50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            ce_q  <= '0;
            cnt_q <= '0;
        end else begin
            ce_q  <= ce_d;
            cnt_q <= cnt_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign ce         = ce_q;
    assign cycle_cnt  = cnt_q;
    assign step_pulse = step_pulse_s;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

    localparam int N_CH    = 4;
    localparam int DIV_W   = 16;
    localparam int STRETCH = 8;
    localparam int DEB_CYC = 4;

    logic             CLOCK_50 = 1'b0;
    logic             RST_N    = 1'b0;
    logic [1:0]       mode     = 2'b00;
    logic [DIV_W-1:0] div_val  = '0;
    logic [N_CH-1:0]  ch_en    = '0;
    logic             step_key = 1'b1;
    logic             clr_cnt  = 1'b0;
    logic             core_rst;
    logic [N_CH-1:0]  ce;
    logic [31:0]      cycle_cnt;
    logic             step_pulse;

    cpu_run_ctrl #(
        .N_CH    (N_CH),
        .DIV_W   (DIV_W),
        .STRETCH (STRETCH),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RST_N      (RST_N),
        .mode       (mode),
        .div_val    (div_val),
        .ch_en      (ch_en),
        .step_key   (step_key),
        .clr_cnt    (clr_cnt),
        .core_rst   (core_rst),
        .ce         (ce),
        .cycle_cnt  (cycle_cnt),
        .step_pulse (step_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_seen = 0;
    int ce_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges since release, a divider phase, key history and
    // a debounced level with a run length of disagreeing samples.
    int          rel_edges;
    logic [1:0]  prev_mode;
    logic [15:0] prev_div;
    int          divcnt;
    logic        kh1, kh2, deb_lvl, pulse_m;
    int          deb_run;
    logic [3:0]  ce_m;
    logic [31:0] cnt_m;

    task automatic model_reset();
        prev_mode = 2'b00; prev_div = 16'h0000; divcnt = 0;
        kh1 = 1'b1; kh2 = 1'b1; deb_lvl = 1'b1; deb_run = 0; pulse_m = 1'b0;
        ce_m = 4'h0; cnt_m = 32'h0;
    endtask

    // Advance one clock with the currently driven inputs, then compare.
    task automatic run_cycle();
        logic crst, chg, tick, np, s;
        if (!RST_N) begin
            model_reset();
            rel_edges = 0;
        end else if (rel_edges < 2) begin
            model_reset();
            rel_edges++;
        end else begin
            crst = (rel_edges < 2 + STRETCH);
            chg  = (mode != prev_mode) || (div_val != prev_div);
            case (mode)
                2'b00:   tick = 1'b1;
                2'b01:   tick = !chg && (divcnt == int'(div_val));
                2'b10:   tick = pulse_m;
                default: tick = 1'b0;
            endcase
            if (crst) tick = 1'b0;
            if (mode == 2'b01 && !crst && !chg && !tick) divcnt++;
            else divcnt = 0;
            np = 1'b0;
            s  = kh2;
            if (s != deb_lvl) begin
                deb_run++;
                if (deb_run == DEB_CYC) begin
                    deb_lvl = s; deb_run = 0; np = !s;
                end
            end else begin
                deb_run = 0;
            end
            kh2 = kh1; kh1 = step_key; pulse_m = np;
            ce_m  = tick ? ch_en : 4'h0;
            cnt_m = clr_cnt ? 32'h0 : cnt_m + (tick ? 32'd1 : 32'd0);
            prev_mode = mode; prev_div = div_val;
            if (rel_edges < 1000) rel_edges++;
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_val("core_rst", {31'b0, core_rst}, (rel_edges < 2 + STRETCH) ? 32'd1 : 32'd0);
        check_val("ce", {28'b0, ce}, {28'b0, ce_m});
        check_val("cycle_cnt", cycle_cnt, cnt_m);
        check_val("step_pulse", {31'b0, step_pulse}, {31'b0, pulse_m});
        if (step_pulse) pulse_seen++;
        if (ce != 4'h0) ce_seen++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Release reset and check core_rst falls on the 10th edge, ce one later.
    task automatic check_release();
        int fall;
        fall = -1;
        RST_N = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            run_cycle();
            if (fall < 0 && core_rst == 1'b0) begin
                fall = i;
                check_val("rel_ce_at_fall", {28'b0, ce}, 32'h0);
            end
            if (fall > 0 && i == fall + 1) check_val("rel_ce_after", {28'b0, ce}, 32'hF);
        end
        check_val("rel_fall_edge", fall, 2 + STRETCH);
        check_val("rel_cnt_from0", cycle_cnt, 14 - (2 + STRETCH));
    endtask

    initial begin
        int p0, c0;
        logic [31:0] hold;
        int hold_left;
        rel_edges = 0;
        model_reset();

        // Reset release in RUN with all channels enabled.
        mode = 2'b00; ch_en = 4'hF; RST_N = 1'b0;
        run_n(3);
        check_release();

        // DIV by 4 with a sparse mask.
        mode = 2'b01; div_val = 16'd3; ch_en = 4'b0101;
        run_n(8);
        clr_cnt = 1'b1; run_cycle(); clr_cnt = 1'b0;
        c0 = ce_seen;
        run_n(40);
        check_val("div_cnt40", cycle_cnt, 32'd10);
        check_val("div_ce40", ce_seen - c0, 32'd10);
        div_val = 16'd0;
        run_cycle();
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            check_val("div0_ce", {28'b0, ce}, 32'h5);
        end

        // STEP with a bouncing press, then release and a second press.
        mode = 2'b10; ch_en = 4'hF;
        run_n(10);
        p0 = pulse_seen; c0 = ce_seen; hold = cnt_m;
        step_key = 1'b1; run_cycle(); step_key = 1'b0; run_cycle();
        step_key = 1'b1; run_cycle(); step_key = 1'b0; run_cycle();
        run_n(10);
        check_val("step1_pulses", pulse_seen - p0, 32'd1);
        check_val("step1_ce", ce_seen - c0, 32'd1);
        check_val("step1_cnt", cycle_cnt, hold + 32'd1);
        step_key = 1'b1; run_n(10);
        step_key = 1'b0; run_n(10);
        check_val("step2_pulses", pulse_seen - p0, 32'd2);
        check_val("step2_cnt", cycle_cnt, hold + 32'd2);
        step_key = 1'b1; run_n(10);

        // Clear wins over a same-cycle tick.
        mode = 2'b00;
        run_n(5);
        clr_cnt = 1'b1; run_cycle(); clr_cnt = 1'b0;
        check_val("clr_wins", cycle_cnt, 32'd0);
        run_cycle();
        check_val("clr_then_tick", cycle_cnt, 32'd1);

        // HALT: presses strobe but produce no ticks.
        mode = 2'b11;
        run_cycle();
        hold = cnt_m; p0 = pulse_seen; c0 = ce_seen;
        step_key = 1'b0; run_n(10);
        step_key = 1'b1; run_n(10);
        check_val("halt_pulses", pulse_seen - p0, 32'd1);
        check_val("halt_ce", ce_seen - c0, 32'd0);
        check_val("halt_cnt_hold", cycle_cnt, hold);

        // Asynchronous reset pulse between edges in RUN.
        mode = 2'b00;
        run_n(5);
        #2 RST_N = 1'b0;
        #1;
        check_val("async_core_rst", {31'b0, core_rst}, 32'd1);
        check_val("async_ce", {28'b0, ce}, 32'h0);
        check_val("async_cnt", cycle_cnt, 32'h0);
        model_reset();
        rel_edges = 0;
        #1;
        check_release();

        // Randomised traffic against the model.
        hold_left = 0;
        for (int seg = 0; seg < 40; seg++) begin
            mode    = 2'($urandom_range(0, 3));
            div_val = 16'($urandom_range(0, 5));
            ch_en   = 4'($urandom_range(0, 15));
            for (int i = 0; i < int'($urandom_range(20, 60)); i++) begin
                clr_cnt = ($urandom_range(0, 31) == 0);
                if (hold_left == 0) begin
                    step_key  = 1'($urandom_range(0, 1));
                    hold_left = $urandom_range(1, 9);
                end else begin
                    hold_left--;
                end
                if ($urandom_range(0, 63) == 0) div_val = 16'($urandom_range(0, 5));
                run_cycle();
            end
        end
        clr_cnt = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cpu_run_ctrl

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of clock-enable channels, 1..16.
REQ-002 Parameter DIV_W, default 16: width of the divider ratio.
REQ-003 Parameter STRETCH, default 8: core reset hold, in cycles after RST_N deasserts, 1..255.
REQ-004 Parameter DEB_CYC, default 1000: cycles step_key must stay stable to count as a change, 2..65535.
REQ-005 CLOCK_50  in  1  sole clock, rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 mode  in  2  run mode: 00 RUN, 01 DIV, 10 STEP, 11 HALT.
REQ-008 div_val  in  DIV_W  DIV mode ratio; one tick per div_val+1 cycles.
REQ-009 ch_en  in  N_CH  per-channel enable mask.
REQ-010 step_key  in  1  raw push button, active-low, asynchronous to CLOCK_50.
REQ-011 clr_cnt  in  1  synchronous clear of cycle_cnt.
REQ-012 core_rst  out  1  active-high synchronous reset to the CPU core.
REQ-013 ce  out  N_CH  registered per-channel clock enables.
REQ-014 cycle_cnt  out  32  count of ticks issued.
REQ-015 step_pulse  out  1  one-cycle strobe per debounced press.

Function
REQ-016 Reset path: 2-FF synchronizer on RST_N. Assertion is asynchronous; deassertion is released through the synchronizer. A stretch counter then holds core_rst high STRETCH further cycles. After that, core_rst stays 0 until the next RST_N assertion.
REQ-017 Debounce: 2-FF synchronizer on step_key, then a stability counter of DEB_CYC cycles. The debounced level changes only after DEB_CYC consecutive equal samples. step_pulse = 1 for exactly one cycle on each debounced 1->0 transition. A release produces no pulse.
REQ-018 Internal tick while core_rst = 1: 0, in every mode.
REQ-019 Internal tick in RUN: 1 every cycle.
REQ-020 Internal tick in DIV: the counter runs 0..div_val and tick = 1 when counter == div_val, after which the counter returns to 0. div_val = 0 gives a tick every cycle.
REQ-021 Internal tick in STEP: tick = step_pulse.
REQ-022 Internal tick in HALT: 0.
REQ-023 Changing mode or div_val clears the divider counter to 0 in the same cycle. The first DIV tick after a change is therefore div_val+1 cycles later.
REQ-024 ce[i] is registered: ce[i] = tick & ch_en[i], delayed by one cycle (latency 1).
REQ-025 cycle_cnt increments by 1 per tick and wraps from 0xFFFFFFFF to 0.
REQ-026 clr_cnt = 1 forces cycle_cnt to 0 next cycle, even if tick = 1 in the same cycle (clear wins).
REQ-027 A step_pulse arriving in RUN, DIV or HALT is ignored for ticking but still appears on step_pulse.
REQ-028 RST_N asserted mid-operation: all outputs take reset values immediately and any pending divider or debounce state is discarded.

Reset
REQ-029 On RST_N = 0: core_rst = 1, ce = 0, cycle_cnt = 0, step_pulse = 0.
REQ-030 On RST_N = 0: divider counter = 0, stretch counter = 0, debounced key level = 1 (released), all synchronizer stages = 1.

Structure
REQ-031 Mode encodings (RUN/DIV/STEP/HALT) live as constants in the shared package mips_ctrl_pkg.
REQ-032 Debounce plus edge detection is one sub-module, key_debounce (parameter DEB_CYC).
REQ-033 Reset synchronizer, stretch counter, divider, counter and ce register stay in cpu_run_ctrl.

Verification
REQ-034 Reset release: RST_N low 3 cycles then high, STRETCH=8, mode=RUN, ch_en=4'hF -> core_rst falls on the 10th rising edge after release (2 sync + 8 stretch). ce becomes 4'hF one cycle later. cycle_cnt counts from 0.
REQ-035 Divider: mode=DIV, div_val=3, ch_en=4'b0101 -> ce = 4'b0101 for one cycle in every 4, otherwise 0. After 40 cycles cycle_cnt = 10. Then div_val=0 -> ce asserted every cycle.
REQ-036 Step debounce: DEB_CYC=4, mode=STEP, step_key bounces 1-0-1-0 at 1-cycle intervals then holds 0 for 10 cycles -> exactly one step_pulse, one ce cycle, cycle_cnt +1. Release and a second press give a second step.
REQ-037 Wrap and clear: cycle_cnt preloaded by running to 0xFFFFFFFF -> next tick gives 0. clr_cnt and tick in the same cycle -> cycle_cnt = 0, not 1.
REQ-038 Async reset mid-run: mode=RUN, RST_N pulsed low between clock edges -> core_rst = 1 and ce = 0 before the next edge. Recovery follows the REQ-034 timing.
REQ-039 HALT: mode switched RUN->HALT with step presses applied -> ce stays 0 and cycle_cnt holds, while step_pulse still strobes.
